iadder_arb_b16: RTL and testbench

- Shares one iadder_B16_6B approximate 16-bit adder among NREQ requesters in the RBM accumulation datapath.
- Arbitration is round-robin.
- Each requester offers an operand pair over a valid/ready handshake.
- Results leave through one registered output stream, tagged with the requester index.
- Sustains one add per cycle, with 1-cycle latency and full back-pressure support.

---
 rtl/iadder_arb_b16.sv | 144 ++++++++++++++
 tb/tb_iadder_arb_b16.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iadder_arb_b16.sv
// Round-robin arbiter sharing one approximate 16-bit adder among NREQ requesters.
// Define IADD_ERR_CHK_EN to add the exact-sum error flag and saturating error counter.
module iadder_B16_6B (
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  output logic [15:0] o_sum
);
  logic [5:0] w_s0;
  logic [5:0] w_s1;
  logic [5:0] w_s2;
  logic [5:0] w_s3;
  logic [3:0] w_s4;
  logic       w_unused;

  assign w_s0 = i_a[5:0] + i_b[5:0];
  assign w_s1 = i_a[8:3] + i_b[8:3] + {5'd0, i_a[0]};
  assign w_s2 = i_a[11:6] + i_b[11:6] + {5'd0, i_a[3]};
  assign w_s3 = i_a[14:9] + i_b[14:9] + {5'd0, i_a[6]};
  assign w_s4 = i_a[15:12] + i_b[15:12] + {3'd0, i_a[9]};

  // overlapping windows only contribute their upper bits
  assign w_unused = ^{w_s1[2:0], w_s2[2:0], w_s3[2:0], w_s4[2:0]};

  assign o_sum = {w_s4[3], w_s3[5:3], w_s2[5:3], w_s1[5:3], w_s0};
endmodule

module iadder_arb_b16 #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [NREQ-1:0]   REQ_VALID,
  output logic [NREQ-1:0]   REQ_READY,
  input  logic [16*NREQ-1:0] REQ_A,
  input  logic [16*NREQ-1:0] REQ_B,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [15:0]       OUT_SUM,
  output logic [IDW-1:0]    OUT_ID,
  output logic              OUT_ERR,
  output logic [15:0]       ERR_CNT
);
  logic [IDW-1:0] r_ptr;
  logic           r_valid;
  logic [15:0]    r_sum;
  logic [IDW-1:0] r_id;

  logic           w_slot_free;
  logic           w_hit;
  logic           w_take;
  logic [IDW-1:0] w_gnt;
  logic [15:0]    w_a;
  logic [15:0]    w_b;
  logic [15:0]    w_sum;
  logic [IDW-1:0] w_ptr_nxt;
  int             w_best;

  assign w_slot_free = !r_valid || OUT_READY;

  // pick the valid requester closest to r_ptr going upward, mod NREQ
  always_comb begin
    int d;
    w_hit  = 1'b0;
    w_best = 0;
    w_gnt  = '0;
    w_a    = '0;
    w_b    = '0;
    d      = 0;
    for (int i = 0; i < NREQ; i++) begin
      d = i - int'(r_ptr);
      if (d < 0) d = d + NREQ;
      if (REQ_VALID[i] && (!w_hit || d < w_best)) begin
        w_hit  = 1'b1;
        w_best = d;
        w_gnt  = IDW'(i);
        w_a    = REQ_A[16*i +: 16];
        w_b    = REQ_B[16*i +: 16];
      end
    end
  end

  assign w_take = w_hit && w_slot_free;

  always_comb begin
    REQ_READY = '0;
    for (int i = 0; i < NREQ; i++) begin
      REQ_READY[i] = w_take && (w_gnt == IDW'(i));
    end
  end

  assign w_ptr_nxt = (w_gnt == IDW'(NREQ - 1)) ? '0 : w_gnt + 1'b1;

  iadder_B16_6B u_add (
    .i_a  (w_a),
    .i_b  (w_b),
    .o_sum(w_sum)
  );

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_valid <= 1'b0;
      r_sum   <= '0;
      r_id    <= '0;
      r_ptr   <= '0;
    end else if (w_slot_free) begin
      r_valid <= w_take;
      if (w_take) begin
        r_sum <= w_sum;
        r_id  <= w_gnt;
        r_ptr <= w_ptr_nxt;
      end
    end
  end

  assign OUT_VALID = r_valid;
  assign OUT_SUM   = r_sum;
  assign OUT_ID    = r_id;

`ifdef IADD_ERR_CHK_EN
  logic [15:0] w_exact;
  logic        r_err;
  logic [15:0] r_cnt;

  assign w_exact = w_a + w_b;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_err <= 1'b0;
      r_cnt <= '0;
    end else begin
      if (w_take) r_err <= (w_sum != w_exact);
      if (r_valid && OUT_READY && r_err && r_cnt != 16'hFFFF)
        r_cnt <= r_cnt + 16'd1;
    end
  end

  assign OUT_ERR = r_err;
  assign ERR_CNT = r_cnt;
`else
  assign OUT_ERR = 1'b0;
  assign ERR_CNT = 16'd0;
`endif
endmodule

// File: tb/tb_iadder_arb_b16.sv
// Bench for iadder_arb_b16: scoreboard monitor plus directed scenario tasks.
// Expected error flags follow IADD_ERR_CHK_EN when defined.
module tb_iadder_arb_b16;
  localparam int NREQ = 4;
  localparam int IDW  = 2;
`ifdef IADD_ERR_CHK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic [3:0]  REQ_VALID = '0;
  logic [3:0]  REQ_READY;
  logic [63:0] REQ_A = '0;
  logic [63:0] REQ_B = '0;
  logic        OUT_VALID;
  logic        OUT_READY = 1'b1;
  logic [15:0] OUT_SUM;
  logic [1:0]  OUT_ID;
  logic        OUT_ERR;
  logic [15:0] ERR_CNT;

  typedef struct packed {
    logic [15:0] sum;
    logic [1:0]  id;
    logic        err;
  } exp_t;

  exp_t q[$];
  int   vecs = 0;
  int   errs = 0;
  int   exp_ptr = 0;
  int   exp_cnt = 0;
  bit   sb_en = 1'b0;

  iadder_arb_b16 #(.NREQ(NREQ), .IDW(IDW)) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .REQ_VALID(REQ_VALID),
    .REQ_READY(REQ_READY),
    .REQ_A    (REQ_A),
    .REQ_B    (REQ_B),
    .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY),
    .OUT_SUM  (OUT_SUM),
    .OUT_ID   (OUT_ID),
    .OUT_ERR  (OUT_ERR),
    .ERR_CNT  (ERR_CNT)
  );

  always #5 CLK = ~CLK;

  function automatic logic [15:0] approx(logic [15:0] a, logic [15:0] b);
    logic [5:0] s0, s1, s2, s3;
    logic [3:0] s4;
    s0 = a[5:0] + b[5:0];
    s1 = a[8:3] + b[8:3] + {5'd0, a[0]};
    s2 = a[11:6] + b[11:6] + {5'd0, a[3]};
    s3 = a[14:9] + b[14:9] + {5'd0, a[6]};
    s4 = a[15:12] + b[15:12] + {3'd0, a[9]};
    return {s4[3], s3[5:3], s2[5:3], s1[5:3], s0};
  endfunction

  function automatic logic [3:0] rr(logic [3:0] v, int p);
    for (int k = 0; k < NREQ; k++) begin
      int j;
      j = (p + k) % NREQ;
      if (v[j]) return 4'(1 << j);
    end
    return 4'b0;
  endfunction

  // scoreboard: pop/compare the shown result, then push the newly accepted one
  always @(negedge CLK) begin
    logic [3:0]  er;
    logic [15:0] a, b;
    exp_t        e;
    int          g;
    if (sb_en) begin
      vecs++;
      if (OUT_VALID !== (q.size() != 0)) begin
        errs++;
        $display("FAIL sb_valid: got %b want %b", OUT_VALID, q.size() != 0);
      end
      er = (q.size() == 0 || OUT_READY) ? rr(REQ_VALID, exp_ptr) : 4'b0;
      vecs++;
      if (REQ_READY !== er) begin
        errs++;
        $display("FAIL sb_ready: got %b want %b", REQ_READY, er);
      end
      vecs++;
      if (ERR_CNT !== 16'(exp_cnt)) begin
        errs++;
        $display("FAIL sb_errcnt: got %0d want %0d", ERR_CNT, exp_cnt);
      end
      if (q.size() != 0) begin
        e = q[0];
        vecs++;
        if ({OUT_SUM, OUT_ID, OUT_ERR} !== e) begin
          errs++;
          $display("FAIL sb_out: got sum=%h id=%0d err=%b want sum=%h id=%0d err=%b",
                   OUT_SUM, OUT_ID, OUT_ERR, e.sum, e.id, e.err);
        end
        if (OUT_READY) begin
          void'(q.pop_front());
          if (e.err && exp_cnt < 65535) exp_cnt++;
        end
      end
      if (er != 4'b0) begin
        g = 0;
        for (int i = 0; i < NREQ; i++) if (er[i]) g = i;
        a = REQ_A[16*g +: 16];
        b = REQ_B[16*g +: 16];
        e.sum = approx(a, b);
        e.id  = 2'(g);
        e.err = ERR_EN && (e.sum != 16'(a + b));
        q.push_back(e);
        exp_ptr = (g + 1) % NREQ;
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    sb_en = 1'b0;
    RST_N = 1'b0;
    REQ_VALID = '0;
    OUT_READY = 1'b1;
    tick();
    tick();
    RST_N = 1'b1;
    q.delete();
    exp_ptr = 0;
    exp_cnt = 0;
    sb_en = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge CLK);
    vecs++;
    if ({OUT_VALID, OUT_SUM, OUT_ID, OUT_ERR} !== 20'd0) begin
      errs++;
      $display("FAIL reset_out: got v=%b s=%h id=%0d e=%b want all 0",
               OUT_VALID, OUT_SUM, OUT_ID, OUT_ERR);
    end
    vecs++;
    if (ERR_CNT !== 16'd0) begin
      errs++;
      $display("FAIL reset_cnt: got %0d want 0", ERR_CNT);
    end
  endtask

  task automatic test_single();
    tick();
    REQ_VALID = 4'b0001;
    REQ_A[15:0] = 16'h0007;
    REQ_B[15:0] = 16'h0001;
    @(negedge CLK);
    vecs++;
    if (REQ_READY !== 4'b0001) begin
      errs++;
      $display("FAIL single_rdy: got %b want 0001", REQ_READY);
    end
    tick();
    REQ_VALID = '0;
    @(negedge CLK);
    vecs++;
    if ({OUT_VALID, OUT_SUM, OUT_ID, OUT_ERR} !== {1'b1, 16'h0008, 2'd0, 1'b0}) begin
      errs++;
      $display("FAIL single_out: got v=%b s=%h id=%0d e=%b want 1 0008 0 0",
               OUT_VALID, OUT_SUM, OUT_ID, OUT_ERR);
    end
  endtask

  task automatic test_approx();
    tick();
    REQ_VALID = 4'b0010;
    REQ_A[31:16] = 16'h01FE;
    REQ_B[31:16] = 16'h0002;
    @(negedge CLK);
    vecs++;
    if (REQ_READY !== 4'b0010) begin
      errs++;
      $display("FAIL approx_rdy: got %b want 0010", REQ_READY);
    end
    tick();
    REQ_VALID = '0;
    @(negedge CLK);
    vecs++;
    if ({OUT_VALID, OUT_SUM, OUT_ID, OUT_ERR} !== {1'b1, 16'h03C0, 2'd1, ERR_EN}) begin
      errs++;
      $display("FAIL approx_out: got v=%b s=%h id=%0d e=%b want 1 03c0 1 %b",
               OUT_VALID, OUT_SUM, OUT_ID, OUT_ERR, ERR_EN);
    end
    tick();
    @(negedge CLK);
    vecs++;
    if (ERR_CNT !== 16'(ERR_EN)) begin
      errs++;
      $display("FAIL approx_cnt: got %0d want %0d", ERR_CNT, ERR_EN);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int k = 0; k < 8; k++) begin
      tick();
      REQ_VALID = 4'hF;
      REQ_A = {$urandom, $urandom};
      REQ_B = {$urandom, $urandom};
      @(negedge CLK);
      vecs++;
      if (REQ_READY !== 4'(1 << (k % 4))) begin
        errs++;
        $display("FAIL b2b_rdy%0d: got %b want %b", k, REQ_READY, 4'(1 << (k % 4)));
      end
      if (k > 0) begin
        vecs++;
        if ({OUT_VALID, OUT_ID} !== {1'b1, 2'((k - 1) % 4)}) begin
          errs++;
          $display("FAIL b2b_id%0d: got v=%b id=%0d want 1 %0d",
                   k, OUT_VALID, OUT_ID, (k - 1) % 4);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    for (int k = 0; k < 3; k++) begin
      tick();
      OUT_READY = 1'b0;
      @(negedge CLK);
      vecs++;
      if ({REQ_READY, OUT_VALID, OUT_ID} !== {4'b0, 1'b1, 2'd3}) begin
        errs++;
        $display("FAIL bp_hold%0d: got rdy=%b v=%b id=%0d want 0000 1 3",
                 k, REQ_READY, OUT_VALID, OUT_ID);
      end
    end
    tick();
    OUT_READY = 1'b1;
    @(negedge CLK);
    vecs++;
    if ({REQ_READY, OUT_ID} !== {4'b0001, 2'd3}) begin
      errs++;
      $display("FAIL bp_release: got rdy=%b id=%0d want 0001 3", REQ_READY, OUT_ID);
    end
    tick();
    REQ_VALID = '0;
    @(negedge CLK);
    vecs++;
    if ({OUT_VALID, OUT_ID} !== {1'b1, 2'd0}) begin
      errs++;
      $display("FAIL bp_next: got v=%b id=%0d want 1 0", OUT_VALID, OUT_ID);
    end
  endtask

  task automatic test_skip_ptr();
    do_reset();
    tick();
    REQ_VALID = 4'b0001;
    tick();
    REQ_VALID = 4'b0101;
    @(negedge CLK);
    vecs++;
    if (REQ_READY !== 4'b0100) begin
      errs++;
      $display("FAIL skip_first: got %b want 0100", REQ_READY);
    end
    tick();
    @(negedge CLK);
    vecs++;
    if ({REQ_READY, OUT_ID} !== {4'b0001, 2'd2}) begin
      errs++;
      $display("FAIL skip_second: got rdy=%b id=%0d want 0001 2", REQ_READY, OUT_ID);
    end
    tick();
    REQ_VALID = '0;
    @(negedge CLK);
    vecs++;
    if (OUT_ID !== 2'd0) begin
      errs++;
      $display("FAIL skip_id: got %0d want 0", OUT_ID);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 300; k++) begin
      tick();
      REQ_VALID = 4'($urandom);
      REQ_A = {$urandom, $urandom};
      REQ_B = {$urandom, $urandom};
      OUT_READY = ($urandom_range(3) != 0);
    end
    tick();
    REQ_VALID = '0;
    OUT_READY = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_reset_mid();
    tick();
    REQ_VALID = 4'b0001;
    REQ_A[15:0] = 16'h01FE;
    REQ_B[15:0] = 16'h0002;
    tick();
    tick();
    REQ_VALID = '0;
    OUT_READY = 1'b0;
    @(negedge CLK);
    vecs++;
    if (OUT_VALID !== 1'b1) begin
      errs++;
      $display("FAIL mid_pre: got v=%b want 1", OUT_VALID);
    end
    tick();
    sb_en = 1'b0;
    RST_N = 1'b0;
    tick();
    RST_N = 1'b1;
    @(negedge CLK);
    vecs++;
    if ({OUT_VALID, ERR_CNT} !== 17'd0) begin
      errs++;
      $display("FAIL mid_rst: got v=%b cnt=%0d want 0 0", OUT_VALID, ERR_CNT);
    end
    q.delete();
    exp_ptr = 0;
    exp_cnt = 0;
    sb_en = 1'b1;
    tick();
    REQ_VALID = 4'hF;
    OUT_READY = 1'b1;
    @(negedge CLK);
    vecs++;
    if (REQ_READY !== 4'b0001) begin
      errs++;
      $display("FAIL mid_ptr: got %b want 0001", REQ_READY);
    end
    tick();
    REQ_VALID = '0;
    tick();
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_approx();
    test_back_to_back();
    test_backpressure();
    test_skip_ptr();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
